pipe_gate: RTL and testbench

Parametrised inter-stage pipeline register for the pipelined MIPS CPU, replacing fixed per-stage gates (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries an arbitrary-width payload with a valid/ready handshake and a two-entry skid buffer, so a downstream stall never drops or duplicates an instruction. A synchronous flush squashes the stage for branch and jump redirects. While the output is invalid, the block presents a configurable NOP payload.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_gate_sat_counter.sv | 19 +
 rtl/pipe_gate.sv | 96 +++++++++
 tb/tb_pipe_gate.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline gate: state codes, MIPS NOP, default stage widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;  // sll $0,$0,0
  localparam int          IFID_WIDTH = 64;

endpackage

// File: rtl/pipe_gate_sat_counter.sv
// Saturating up-counter used for pipeline stall/bubble statistics.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_gate.sv
// Inter-stage pipeline register with valid/ready handshake, skid buffer and flush.
// Optional statistics counters are built when PIPE_GATE_STATS_EN is defined.
//
// state | meaning
// EMPTY | nothing held, out_data shows NOP_VALUE
// BUSY  | main register holds the output payload
// FULL  | main and skid registers both hold payloads, input stalled
module pipe_gate
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = IFID_WIDTH,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(MIPS_NOP),
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
`ifdef PIPE_GATE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] bubble_count
`endif
);

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             take;

  // Outputs decode only the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = (state == EMPTY) ? NOP_VALUE : main_q;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (accept && take) begin
            main_q <= in_data;
          end else if (accept) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (take) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_GATE_STATS_EN
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid & out_ready),
    .count (bubble_count)
  );
`else
  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end
`endif

endmodule

// File: tb/tb_pipe_gate.sv
// Self-checking bench for pipe_gate: directed vector table, multi-cycle sequences, ordering stress.
// Stats checks run when PIPE_GATE_STATS_EN is defined.
module tb_pipe_gate;

  localparam int               W   = 16;
  localparam logic [W-1:0]     NOP = 16'hDEAD;
  localparam int               CW  = 4;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_GATE_STATS_EN
  logic [CW-1:0] stall_count, bubble_count;
`endif

  always #5 clk = ~clk;

  pipe_gate #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef PIPE_GATE_STATS_EN
    ,
    .stall_count  (stall_count),
    .bubble_count (bubble_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         r, f, iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ov, ir;
    logic [W-1:0] od;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, f, iv, input logic [W-1:0] d, input logic ordy,
                              input logic ov, ir, input logic [W-1:0] od);
    vec_t v;
    v = '{r: r, f: f, iv: iv, d: d, ordy: ordy, ov: ov, ir: ir, od: od};
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs (just after an edge), then step past the next edge.
  task automatic apply(input logic r, f, iv, input logic [W-1:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_out, next_in, cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //   rst flush iv  data     ordy   ov  ir  out_data
    add(1, 0, 0, 16'h0000, 0,   0, 1, NOP);     // reset
    add(0, 0, 1, 16'h0001, 1,   1, 1, 16'h0001);// streaming
    add(0, 0, 1, 16'h0002, 1,   1, 1, 16'h0002);
    add(0, 0, 1, 16'h0003, 1,   1, 1, 16'h0003);
    add(0, 0, 1, 16'h0004, 1,   1, 1, 16'h0004);
    add(0, 0, 0, 16'h0000, 1,   0, 1, NOP);
    add(0, 0, 1, 16'h000A, 0,   1, 1, 16'h000A);// stall and skid
    add(0, 0, 1, 16'h000B, 0,   1, 0, 16'h000A);
    add(0, 0, 0, 16'h0000, 0,   1, 0, 16'h000A);
    add(0, 0, 0, 16'h0000, 1,   1, 1, 16'h000B);
    add(0, 0, 0, 16'h0000, 1,   0, 1, NOP);
    add(0, 0, 1, 16'h000A, 0,   1, 1, 16'h000A);// flush from FULL
    add(0, 0, 1, 16'h000B, 0,   1, 0, 16'h000A);
    add(0, 1, 1, 16'h000C, 0,   0, 1, NOP);
    add(0, 0, 0, 16'h0000, 1,   0, 1, NOP);
    add(0, 0, 1, 16'h000A, 0,   1, 1, 16'h000A);// flush drops a same-cycle accept
    add(0, 1, 1, 16'h000C, 1,   0, 1, NOP);
    add(0, 0, 0, 16'h0000, 1,   0, 1, NOP);
    add(0, 0, 1, 16'h0007, 0,   1, 1, 16'h0007);// reset mid-stream in BUSY
    add(1, 0, 0, 16'h0000, 0,   0, 1, NOP);
    add(0, 0, 1, 16'h0005, 0,   1, 1, 16'h0005);
    add(0, 0, 1, 16'h0006, 0,   1, 0, 16'h0005);// reset with flush while FULL
    add(1, 1, 1, 16'h0009, 1,   0, 1, NOP);
    add(0, 0, 1, 16'h0008, 1,   1, 1, 16'h0008);
    add(0, 0, 0, 16'h0000, 1,   0, 1, NOP);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
      check($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vecs[i].od));
    end

    // Ordering under random in_valid/out_ready.
    apply(1, 0, 0, '0, 0);
    exp_out = 0; next_in = 0; cyc = 0;
    while (exp_out < 1000 && cyc < 20000) begin
      rst = 1'b0; flush = 1'b0;
      in_valid  = (next_in < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = W'(next_in);
      out_ready = ($urandom_range(0, 1) == 1);
      #2;
      if (in_valid && in_ready) next_in++;
      if (out_valid && out_ready) begin
        if (out_data !== W'(exp_out)) check("random_order", 32'(out_data), 32'(exp_out));
        else checks++;
        exp_out++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("random_count", 32'(exp_out), 32'd1000);

`ifdef PIPE_GATE_STATS_EN
    apply(1, 0, 0, '0, 0);
    check("stats_rst_stall",  32'(stall_count),  32'd0);
    check("stats_rst_bubble", 32'(bubble_count), 32'd0);
    apply(0, 0, 1, 16'h0001, 0);
    for (int i = 0; i < 20; i++) apply(0, 0, 0, '0, 0);
    check("stats_stall_sat",  32'(stall_count),  32'd15);
    check("stats_bubble_0",   32'(bubble_count), 32'd0);
    apply(0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, '0, 1);
    check("stats_bubble_3",   32'(bubble_count), 32'd3);
    apply(0, 1, 0, '0, 0);
    check("stats_flush_stall",  32'(stall_count),  32'd15);
    check("stats_flush_bubble", 32'(bubble_count), 32'd3);
    apply(1, 0, 0, '0, 0);
    check("stats_clear_stall",  32'(stall_count),  32'd0);
    check("stats_clear_bubble", 32'(bubble_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
